multicycle_ctrl: RTL and testbench

- Multi-cycle successor to the single-cycle CPU control path.
- One FSM sequences each instruction over 3–5 cycles on a shared datapath (one ALU, one memory port).
- Memory accesses use a ready handshake with stall, a parametrised timeout and a sticky fault.
- The block sits between the instruction register decode fields (opcode, funct) and the datapath muxes and enables. It replaces control plus ALUControl in the multi-cycle core.

---
 rtl/mips_defs.sv | 67 ++++++
 rtl/mc_timeout.sv | 35 +++
 rtl/multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the multi-cycle MIPS control path: instruction
// field encodings, ALU control codes, FSM state encoding and datapath
// mux select codes.
package mips_defs;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field IR[5:0] for R-type
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control (MIPSALU encoding)
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // Register destination select
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // Write-back source select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_ONE    = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

endpackage

// File: rtl/mc_timeout.sv
// Memory wait-state watchdog.
//   clk, rst_n  : clock, async active-low reset
//   wait_st     : FSM is in a memory-wait state (FETCH, MEM_RD, MEM_WR)
//   mem_ready   : memory completes the request this cycle
//   expired     : counter reached TIMEOUT with mem_ready low (0 when TIMEOUT = 0)
module mc_timeout #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_st,
  input  logic mem_ready,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt_q;

  assign expired = (TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == LIMIT);

  // A wait state is only ever left via mem_ready or expiry, so clearing on
  // those (or outside a wait state) covers every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!wait_st || mem_ready || expired || (TIMEOUT == 0)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 3-5 cycles
// on a shared ALU / memory port, with memory-ready stall, wait timeout and
// sticky fault.
//   clk, reset          : clock, async active-low reset
//   opcode, funct, zero : IR decode fields and ALU zero flag
//   mem_ready           : memory handshake completion
//   mem_req, mem_we, i_or_d          : memory port control
//   ir_write, pc_write, pc_src       : IR / PC update
//   reg_write, reg_dst, mem_to_reg   : register file write-back
//   alu_src_a, alu_src_b, alu_ctl    : ALU operand / operation
//   state, instr_done, retired, fault: status and debug
module multicycle_ctrl
  import mips_defs::*;
#(
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned UNIFIED_MEM = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  state_t state_q, state_d;
  logic   timeout;
  logic   wait_st;
  logic   is_rtype;

  logic   mem_req_c, mem_we_c, i_or_d_c, ir_write_c, pc_write_c;
  logic   reg_write_c, done_c;

  logic [CNT_W-1:0] retired_q;

  assign is_rtype = (opcode == OP_RTYPE);
  assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (reset),
    .wait_st   (wait_st),
    .mem_ready (mem_ready),
    .expired   (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (done_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    i_or_d_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    pc_src      = PC_SRC_ALU;
    reg_dst     = REG_DST_RT;
    mem_to_reg  = M2R_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = SRC_B_RT;
    alu_ctl     = ALU_ADD;

    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = SRC_B_ONE;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J, OP_JAL:     state_d = S_JUMP;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
              FN_JR:                  state_d = S_JUMP;
              default:                state_d = S_FAULT;
            endcase
          end
          default: state_d = S_FAULT;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
        state_d = S_WB_R;
      end

      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst     = REG_DST_RD;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctl   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d   = S_WB_I;
      end

      S_WB_I: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req_c = 1'b1;
        i_or_d_c  = 1'b1;
        if (mem_ready)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_FAULT;
      end

      S_WB_MEM: begin
        reg_write_c = 1'b1;
        mem_to_reg  = M2R_MDR;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        i_or_d_c  = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUB;
        pc_src     = PC_SRC_ALUOUT;
        pc_write_c = (opcode == OP_BNE) ? !zero : zero;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src     = is_rtype ? PC_SRC_RS : PC_SRC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write_c = 1'b1;
          reg_dst     = REG_DST_RA;
          mem_to_reg  = M2R_PC;
        end
        done_c  = 1'b1;
        state_d = S_FETCH;
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_FAULT;
    endcase
  end

  // Reset returns the FSM to FETCH, which would otherwise request memory;
  // gating with reset keeps every enable low for as long as reset is held.
  assign mem_req    = mem_req_c   & reset;
  assign mem_we     = mem_we_c    & reset;
  assign ir_write   = ir_write_c  & reset;
  assign pc_write   = pc_write_c  & reset;
  assign reg_write  = reg_write_c & reset;
  assign instr_done = done_c      & reset;
  assign i_or_d     = (UNIFIED_MEM != 0) ? i_or_d_c : 1'b0;

  assign state   = state_q;
  assign retired = retired_q;
  assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic        reg_write, alu_src_a, instr_done, fault;
  logic [3:0]  alu_ctl, state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // Results of the last run_instr call
  int         r_cycles, r_wr, r_dwait, r_iord_bad;
  logic [3:0] r_ctl3;
  logic       r_pcw, r_rw, r_we;
  logic [1:0] r_pcs, r_dst, r_m2r;

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32), .UNIFIED_MEM(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
    .state(state), .instr_done(instr_done), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until instr_done (bounded).
  // mem_ready is low on cycle numbers [stall_at, stall_at+stall).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int stall_at, input int stall);
    bit done = 0;
    opcode = op; funct = fn; zero = z;
    r_cycles = 0; r_wr = 0; r_dwait = 0; r_iord_bad = 0; r_ctl3 = '0;
    for (int i = 1; i <= 40 && !done; i++) begin
      mem_ready = (stall > 0 && i >= stall_at && i < stall_at + stall) ? 1'b0 : 1'b1;
      #1;
      r_cycles = i;
      if (reg_write) r_wr++;
      if (mem_req && i_or_d) r_dwait++;
      if (mem_req && !mem_ready && !i_or_d) r_iord_bad++;
      if (i == 3) r_ctl3 = alu_ctl;
      if (instr_done) begin
        done = 1;
        r_pcw = pc_write; r_pcs = pc_src; r_rw = reg_write; r_we = mem_we;
        r_dst = reg_dst; r_m2r = mem_to_reg;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("instr_done_bound", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b0; opcode = OP_RTYPE; funct = FN_ADD; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    // Reset held: FETCH, counters clear, enables forced low
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b1;

    // add, cycle by cycle
    opcode = OP_RTYPE; funct = FN_ADD; mem_ready = 1'b1; #1;
    check("add_c1_state", 32'(state), 32'(S_FETCH));
    check("add_c1_ctrl", {mem_req, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctl},
          {1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 4'b0010});
    tick();
    check("add_c2_state", 32'(state), 32'(S_DECODE));
    check("add_c2_srcb", 32'(alu_src_b), 32'd3);
    tick();
    check("add_c3_state", 32'(state), 32'(S_EXEC_R));
    check("add_c3_alu", {alu_src_a, alu_src_b, alu_ctl}, {1'b1, 2'd0, 4'b0010});
    tick();
    check("add_c4_state", 32'(state), 32'(S_WB_R));
    check("add_c4_wb", {reg_write, reg_dst, mem_to_reg, instr_done}, {1'b1, 2'd1, 2'd0, 1'b1});
    check("add_c4_retired", retired, 32'd0);
    tick();
    check("add_retired", retired, 32'd1);
    check("add_done_low", 32'(instr_done), 32'd0);

    // R / I ALU ops: cycle count and ALU control in the execute cycle
    run_instr(OP_RTYPE, FN_SUB, 1'b0, 0, 0);
    check("sub_cycles", r_cycles, 4); check("sub_ctl", 32'(r_ctl3), 32'h6);
    run_instr(OP_RTYPE, FN_SLT, 1'b0, 0, 0);
    check("slt_cycles", r_cycles, 4); check("slt_ctl", 32'(r_ctl3), 32'h7);
    run_instr(OP_ADDI, 6'h15, 1'b0, 0, 0);
    check("addi_cycles", r_cycles, 4); check("addi_ctl", 32'(r_ctl3), 32'h2);
    check("addi_dst", 32'(r_dst), 32'd0);
    run_instr(OP_XORI, 6'h00, 1'b0, 0, 0);
    check("xori_cycles", r_cycles, 4); check("xori_ctl", 32'(r_ctl3), 32'hD);

    // lw with 3 stall cycles in MEM_RD (cycle 4)
    run_instr(OP_LW, 6'h00, 1'b0, 4, 3);
    check("lw_cycles", r_cycles, 8);
    check("lw_wr_once", r_wr, 1);
    check("lw_m2r", 32'(r_m2r), 32'd1);
    check("lw_dreq_held", r_dwait, 4);
    check("lw_iord_bad", r_iord_bad, 0);

    run_instr(OP_SW, 6'h00, 1'b0, 0, 0);
    check("sw_cycles", r_cycles, 4); check("sw_we", 32'(r_we), 32'd1);
    check("sw_no_wr", r_wr, 0);

    run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    check("beq_cycles", r_cycles, 3); check("beq_ctl", 32'(r_ctl3), 32'h6);
    check("beq_pc", {r_pcw, r_pcs}, {1'b1, 2'd1});
    run_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
    check("bne_cycles", r_cycles, 3); check("bne_pcw", 32'(r_pcw), 32'd0);

    run_instr(OP_JAL, 6'h00, 1'b0, 0, 0);
    check("jal_cycles", r_cycles, 3);
    check("jal_ctrl", {r_pcw, r_pcs, r_rw, r_dst, r_m2r}, {1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
    run_instr(OP_RTYPE, FN_JR, 1'b0, 0, 0);
    check("jr_cycles", r_cycles, 3);
    check("jr_ctrl", {r_pcw, r_pcs, r_rw}, {1'b1, 2'd3, 1'b0});
    check("retired_11", retired, 32'd11);

    // Timeout boundary: ready arrives on the limit cycle (5th FETCH cycle)
    opcode = OP_RTYPE; funct = FN_ADD; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("tmo_still_fetch", 32'(state), 32'(S_FETCH));
    mem_ready = 1'b1; #1;
    check("tmo_limit_irw", 32'(ir_write), 32'd1);
    tick();
    check("tmo_limit_decode", 32'(state), 32'(S_DECODE));
    check("tmo_limit_nofault", 32'(fault), 32'd0);
    tick(); tick(); tick();
    check("retired_12", retired, 32'd12);

    // Timeout: mem_ready stuck low in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("tmo_fault_state", 32'(state), 32'(S_FAULT));
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_enables", {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done}, 6'd0);
    mem_ready = 1'b1; tick(); tick();
    check("fault_sticky", 32'(state), 32'(S_FAULT));

    reset = 1'b0; #1;
    check("rst2_state", 32'(state), 32'(S_FETCH));
    check("rst2_fault", 32'(fault), 32'd0);
    check("rst2_retired", retired, 32'd0);
    tick(); reset = 1'b1;

    // Illegal opcode: FETCH, DECODE, then FAULT
    opcode = 6'b111111; mem_ready = 1'b1;
    tick(); tick();
    check("illegal_fault", 32'(state), 32'(S_FAULT));
    check("illegal_fault_flag", 32'(fault), 32'd1);
    reset = 1'b0; tick(); reset = 1'b1;

    // sw interrupted by reset while stalled in MEM_WR
    opcode = OP_SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("sw_memwr_state", 32'(state), 32'(S_MEM_WR));
    check("sw_memwr_we", 32'(mem_we), 32'd1);
    #1; reset = 1'b0; #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_state", 32'(state), 32'(S_FETCH));
    check("abort_retired", retired, 32'd0);
    check("abort_fault", 32'(fault), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
